ether_import: RTL

ETHER_IMPORT -- requirements
Module: ether_import

---
 rtl/ether_import_pkg.sv | 23 ++
 rtl/ether_rx.sv | 62 ++++++
 rtl/ether_import.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ether_import_pkg.sv
// Shared types for the Ethernet frame-buffer importer: display geometry,
// packet framing constants and the frame-buffer address helper.
package ether_import_pkg;

    localparam int DISPLAY_WIDTH  = 16;
    localparam int DISPLAY_HEIGHT = 12;
    localparam int H_BITS         = 4;
    localparam int ADDR_BITS      = 8;

    // Packet framing: 8-dibit header, 16'hFFFF marks a frame-start packet
    // that must be exactly 100 dibits of 2'b11 including the header.
    localparam logic [15:0] FRAME_START_MARKER = 16'hFFFF;
    localparam int          FRAME_START_DIBITS = 100;
    localparam int          HEADER_DIBITS      = 8;
    localparam int          ROW_DIBITS         = 2 * DISPLAY_WIDTH;

    // Frame-buffer address of a pixel: (row << H_BITS) + col.
    function automatic logic [ADDR_BITS-1:0] pixel_addr(input logic [15:0]       row,
                                                        input logic [H_BITS-1:0] col);
        pixel_addr = (ADDR_BITS'(row) << H_BITS) + ADDR_BITS'(col);
    endfunction

endpackage

// File: rtl/ether_rx.sv
// RMII receive front end: waits for an idle carrier, strips the preamble and
// SFD, then presents each payload dibit on axiov/axiod until eth_crsdv falls.
module ether_rx
    import ether_import_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       eth_crsdv,
    input  logic [1:0] eth_rxd,
    output logic       axiov,
    output logic [1:0] axiod
);

    typedef enum logic [1:0] {
        RX_CARRIER_WAIT,  // need eth_crsdv low before trusting a preamble
        RX_PREAMBLE,      // 01 dibits until the 11 that closes the SFD
        RX_DATA           // payload dibits
    } rx_state_t;

    rx_state_t  state_q, state_d;
    logic       axiov_d;

    // Next-state and payload-valid decode.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        axiov_d = 1'b0;
        case (state_q)
            RX_CARRIER_WAIT: begin
                if (!eth_crsdv) state_d = RX_PREAMBLE;
            end
            RX_PREAMBLE: begin
                if (eth_crsdv) begin
                    if (eth_rxd == 2'b11)      state_d = RX_DATA;
                    else if (eth_rxd == 2'b10) state_d = RX_CARRIER_WAIT;
                end
            end
            RX_DATA: begin
                if (eth_crsdv) axiov_d = 1'b1;
                else           state_d = RX_PREAMBLE;
            end
            default: state_d = RX_CARRIER_WAIT;
        endcase
    end

    // State and registered payload outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= RX_CARRIER_WAIT;
            axiov   <= 1'b0;
            axiod   <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments for all clocked state so every
            // register samples the pre-edge values regardless of order.
            state_q <= state_d;
            axiov   <= axiov_d;
            axiod   <= axiov_d ? eth_rxd : 2'b00;
        end
    end

endmodule

// File: rtl/ether_import.sv
// Decodes RMII packets into frame-buffer writes: a 16-bit header selects a
// frame-start packet or a row of 4-bit pixels; malformed packets pulse err_out.
module ether_import
    import ether_import_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 eth_crsdv,
    input  logic [1:0]           eth_rxd,
    output logic [ADDR_BITS-1:0] write_addr_out,
    output logic [3:0]           write_data_out,
    output logic                 write_en_out,
    output logic                 running,
    output logic                 frame_start_out,
    output logic                 row_done_out,
    output logic [15:0]          row_out,
    output logic                 err_out
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PIXELS,
        ST_FRAME,
        ST_DRAIN
    } state_t;

    logic       axiov;
    logic [1:0] axiod;

    ether_rx u_ether_rx (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .eth_crsdv (eth_crsdv),
        .eth_rxd   (eth_rxd),
        .axiov     (axiov),
        .axiod     (axiod)
    );

    state_t                state_q, state_d;
    // cnt counts header dibits, then pixel dibits (row) or total dibits (frame).
    logic [7:0]            cnt_q, cnt_d;
    logic [15:0]           hdr_q, hdr_d, hdr_next;
    logic [15:0]           row_q, row_d;
    logic [1:0]            hi_q, hi_d;
    logic                  frame_ok_q, frame_ok_d;
    logic                  wr_en_d, err_d, frame_d, row_done_d;
    logic [ADDR_BITS-1:0]  wr_addr_d;
    logic [3:0]            wr_data_d;
    logic [15:0]           row_out_d;

    assign running = (state_q != ST_IDLE);

    // Packet decode: next state, datapath updates and one-cycle strobes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hdr_d      = hdr_q;
        hdr_next   = hdr_q | (16'(axiod) << {cnt_q[2:0], 1'b0});
        row_d      = row_q;
        hi_d       = hi_q;
        frame_ok_d = frame_ok_q;
        wr_en_d    = 1'b0;
        err_d      = 1'b0;
        frame_d    = 1'b0;
        row_done_d = 1'b0;
        wr_addr_d  = write_addr_out;
        wr_data_d  = write_data_out;
        row_out_d  = row_out;
        case (state_q)
            ST_IDLE: begin
                if (axiov) begin
                    state_d = ST_HEADER;
                    hdr_d   = {14'd0, axiod};
                    cnt_d   = 8'd1;
                end
            end
            ST_HEADER: begin
                if (!axiov) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    hdr_d = hdr_next;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'(HEADER_DIBITS - 1)) begin
                        if (hdr_next == FRAME_START_MARKER) begin
                            state_d    = ST_FRAME;
                            frame_ok_d = 1'b1;
                        end else if (hdr_next < 16'(DISPLAY_HEIGHT)) begin
                            state_d = ST_PIXELS;
                            row_d   = hdr_next;
                            cnt_d   = 8'd0;
                        end else begin
                            state_d = ST_DRAIN;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
            ST_PIXELS: begin
                if (axiov) begin
                    if (cnt_q == 8'(ROW_DIBITS)) begin
                        state_d = ST_DRAIN;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                        if (!cnt_q[0]) begin
                            hi_d = axiod;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = pixel_addr(row_q, H_BITS'(cnt_q >> 1));
                            wr_data_d = {hi_q, axiod};
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                    if (cnt_q == 8'(ROW_DIBITS)) begin
                        row_done_d = 1'b1;
                        row_out_d  = row_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_FRAME: begin
                if (axiov) begin
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                    if (axiod != 2'b11) frame_ok_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    if (cnt_q == 8'(FRAME_START_DIBITS) && frame_ok_q) frame_d = 1'b1;
                    else                                                err_d   = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!axiov) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q         <= ST_IDLE;
            cnt_q           <= 8'd0;
            hdr_q           <= 16'd0;
            row_q           <= 16'd0;
            hi_q            <= 2'b00;
            frame_ok_q      <= 1'b0;
            write_en_out    <= 1'b0;
            write_addr_out  <= '0;
            write_data_out  <= 4'd0;
            err_out         <= 1'b0;
            frame_start_out <= 1'b0;
            row_done_out    <= 1'b0;
            row_out         <= 16'd0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            hdr_q           <= hdr_d;
            row_q           <= row_d;
            hi_q            <= hi_d;
            frame_ok_q      <= frame_ok_d;
            write_en_out    <= wr_en_d;
            write_addr_out  <= wr_addr_d;
            write_data_out  <= wr_data_d;
            err_out         <= err_d;
            frame_start_out <= frame_d;
            row_done_out    <= row_done_d;
            row_out         <= row_out_d;
        end
    end

endmodule
